wf_iq_player: RTL and testbench

- Single-clock IQ sample playback engine in the adc_clk domain; the transmit-side counterpart of the waterfall IQ sampler.
- Software loads I/Q pairs into an internal buffer, then the block streams them out at a programmable rate: one pair every `interp` clocks, zero-order hold, one-shot or continuous loop.
- Output feeds the mixer/CIC path as a synthetic test source for loopback verification of the waterfall and receiver chains.
- All control pulses arrive already synchronised into adc_clk.

---
 rtl/wf_iq_player_pkg.sv | 27 ++
 rtl/wf_iq_player_if.sv | 41 ++++
 rtl/wf_iq_play_ram.sv | 34 +++
 rtl/wf_iq_player.sv | 178 +++++++++++++++++
 tb/tb_wf_iq_player.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/wf_iq_player_pkg.sv
// -----------------------------------------------------------------------------
// wf_iq_player_pkg
// Shared definitions for the IQ playback engine:
//   WF_PLAY_DEPTH : default buffer capacity in IQ pairs (power of two)
//   state_t       : FSM state type, with ST_IDLE / ST_PRIME / ST_PLAY
//   wf_clog2      : constant-foldable ceil(log2()) used to size addresses
// -----------------------------------------------------------------------------
package wf_iq_player_pkg;

    localparam int WF_PLAY_DEPTH = 1024;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;

    function automatic int wf_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wf_iq_player_if.sv
// -----------------------------------------------------------------------------
// wf_iq_player_if
// Control/data bundle between software-facing logic and the IQ player.
//   Write side : wr_rst, wr_i, wr_q, wr_data
//   Control    : set_interp, interp_val, start, stop, loop
//   Output     : out_strobe, out_i, out_q, busy, done, wr_count, overflow
// master drives the write/control side, slave is the player itself.
// -----------------------------------------------------------------------------
interface wf_iq_player_if #(
    parameter int W  = 16,
    parameter int MD = 16,
    parameter int AW = 10
);
    logic                wr_rst;
    logic                wr_i;
    logic                wr_q;
    logic signed [W-1:0] wr_data;
    logic                set_interp;
    logic [MD-1:0]       interp_val;
    logic                start;
    logic                stop;
    logic                loop;

    logic                out_strobe;
    logic signed [W-1:0] out_i;
    logic signed [W-1:0] out_q;
    logic                busy;
    logic                done;
    logic [AW:0]         wr_count;
    logic                overflow;

    modport master (
        output wr_rst, wr_i, wr_q, wr_data, set_interp, interp_val, start, stop, loop,
        input  out_strobe, out_i, out_q, busy, done, wr_count, overflow
    );

    modport slave (
        input  wr_rst, wr_i, wr_q, wr_data, set_interp, interp_val, start, stop, loop,
        output out_strobe, out_i, out_q, busy, done, wr_count, overflow
    );
endinterface

// File: rtl/wf_iq_play_ram.sv
// -----------------------------------------------------------------------------
// wf_iq_play_ram
// DEPTH x DW simple dual-port RAM, one write port and one read port with a
// registered read (data appears the cycle after the address). No reset on
// the array or read register so it maps onto block RAM.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address, sampled every cycle
//   o_rdata : read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module wf_iq_play_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata_p1;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata_p1 <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata_p1;
endmodule

// File: rtl/wf_iq_player.sv
// -----------------------------------------------------------------------------
// wf_iq_player
// IQ sample playback engine. Software loads I/Q pairs into the buffer, then
// the block replays them one pair every `interp` clocks (zero-order hold),
// either once or continuously.
//   i_adc_clk : sole clock
//   i_reset   : asynchronous active-high reset
//   io_bus    : wf_iq_player_if.slave (write port, control pulses, outputs)
// -----------------------------------------------------------------------------
module wf_iq_player
    import wf_iq_player_pkg::*;
#(
    parameter int DEPTH = WF_PLAY_DEPTH,
    parameter int AW    = wf_clog2(DEPTH),
    parameter int W     = 16,
    parameter int MD    = 16
) (
    input  logic          i_adc_clk,
    input  logic          i_reset,
    wf_iq_player_if.slave io_bus
);
    state_t              r_state;
    logic [AW-1:0]       r_idx;
    logic [MD-1:0]       r_cnt;
    logic [MD-1:0]       r_interp;
    logic [MD-1:0]       r_interp_pend;
    logic                r_loop;
    logic                r_last;
    logic                r_strobe;
    logic                r_done;
    logic signed [W-1:0] r_out_i;
    logic signed [W-1:0] r_out_q;
    logic signed [W-1:0] r_pend_i;
    logic [AW:0]         r_wr_count;
    logic                r_overflow;

    logic                w_idle;
    logic                w_prime;
    logic                w_play;
    logic                w_start;
    logic                w_stop;
    logic                w_period_end;
    logic                w_fire;
    logic                w_finish;
    logic                w_at_end;
    logic                w_full;
    logic                w_wr_en;
    logic [MD-1:0]       w_interp_req;
    logic [MD-1:0]       w_pend_nxt;
    logic [AW-1:0]       w_idx_nxt;
    logic [2*W-1:0]      w_rd_data_p1;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_prime = (r_state == ST_PRIME);
    assign w_play  = (r_state == ST_PLAY);

    // stop beats a same-cycle start; an empty buffer never starts
    assign w_start = w_idle && io_bus.start && !io_bus.stop && (r_wr_count != '0);
    assign w_stop  = !w_idle && io_bus.stop;

    assign w_period_end = w_play && (r_cnt == r_interp - MD'(1));

    // w_fire: a new pair is strobed at the next edge. The first pair leaves
    // PRIME; after that one pair per period until the last one-shot pair's
    // period has run out, which instead finishes the pass.
    assign w_fire   = !w_stop && (w_prime || (w_period_end && !r_last));
    assign w_finish = !w_stop && w_period_end && r_last;

    assign w_at_end = ({1'b0, r_idx} == r_wr_count - (AW+1)'(1));
    assign w_full   = (r_wr_count == (AW+1)'(DEPTH));

    assign w_interp_req = (io_bus.interp_val == '0) ? MD'(1) : io_bus.interp_val;
    assign w_pend_nxt   = io_bus.set_interp ? w_interp_req : r_interp_pend;

    // The write pointer is frozen while playing so end-of-buffer detection
    // stays consistent for the pass in progress.
    assign w_wr_en = w_idle && io_bus.wr_q && !io_bus.wr_rst && !w_full;

    // The RAM is addressed with the next value of r_idx, so its registered
    // output always holds pair r_idx: the pair to strobe is prefetched and
    // interp = 1 runs without bubbles.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_idle || w_stop || w_finish) begin
            w_idx_nxt = '0;
        end else if (w_fire) begin
            w_idx_nxt = w_at_end ? '0 : r_idx + AW'(1);
        end
    end

    wf_iq_play_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (2*W)
    ) u_ram (
        .i_clk   (i_adc_clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_count[AW-1:0]),
        .i_wdata ({r_pend_i, io_bus.wr_data}),
        .i_raddr (w_idx_nxt),
        .o_rdata (w_rd_data_p1)
    );

    // Playback FSM, period counter and output hold registers
    always_ff @(posedge i_adc_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_interp      <= MD'(1);
            r_interp_pend <= MD'(1);
            r_loop        <= 1'b0;
            r_last        <= 1'b0;
            r_strobe      <= 1'b0;
            r_done        <= 1'b0;
            r_out_i       <= '0;
            r_out_q       <= '0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_strobe      <= w_fire;
            r_done        <= w_finish;
            r_interp_pend <= w_pend_nxt;

            // a new period length only takes hold on a period boundary
            if (!w_play || w_period_end) r_interp <= w_pend_nxt;

            r_cnt <= (w_play && !w_fire) ? r_cnt + MD'(1) : '0;

            if (w_fire) begin
                r_out_i <= signed'(w_rd_data_p1[2*W-1:W]);
                r_out_q <= signed'(w_rd_data_p1[W-1:0]);
                r_last  <= w_at_end && !r_loop;
            end else if (w_stop || w_finish) begin
                r_out_i <= '0;
                r_out_q <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_PRIME;
                        r_loop  <= io_bus.loop;
                        r_last  <= 1'b0;
                    end
                end
                ST_PRIME: r_state <= w_stop ? ST_IDLE : ST_PLAY;
                ST_PLAY:  if (w_stop || w_finish) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer write side: pending I, write pointer, overflow flag
    always_ff @(posedge i_adc_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_i   <= '0;
            r_wr_count <= '0;
            r_overflow <= 1'b0;
        end else if (w_idle) begin
            if (io_bus.wr_i) r_pend_i <= io_bus.wr_data;
            if (io_bus.wr_rst) begin
                r_wr_count <= '0;
                r_overflow <= 1'b0;
            end else if (io_bus.wr_q) begin
                if (w_full) r_overflow <= 1'b1;
                else        r_wr_count <= r_wr_count + (AW+1)'(1);
            end
        end
    end

    assign io_bus.out_strobe = r_strobe;
    assign io_bus.out_i      = r_out_i;
    assign io_bus.out_q      = r_out_q;
    assign io_bus.busy       = !w_idle;
    assign io_bus.done       = r_done;
    assign io_bus.wr_count   = r_wr_count;
    assign io_bus.overflow   = r_overflow;
endmodule

// File: tb/tb_wf_iq_player.sv
// -----------------------------------------------------------------------------
// tb_wf_iq_player
// Directed bench for wf_iq_player with a 16-pair buffer. Inputs are driven
// 1 time unit after each rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_wf_iq_player;
    import wf_iq_player_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = wf_clog2(DEPTH);
    localparam int W     = 16;
    localparam int MD    = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    wf_iq_player_if #(.W(W), .MD(MD), .AW(AW)) bus ();

    wf_iq_player #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (W),
        .MD    (MD)
    ) dut (
        .i_adc_clk (clk),
        .i_reset   (rst),
        .io_bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_pair(input int iv, input int qv);
        bus.wr_i    = 1'b1;
        bus.wr_data = W'(iv);
        tick();
        bus.wr_i    = 1'b0;
        bus.wr_q    = 1'b1;
        bus.wr_data = W'(qv);
        tick();
        bus.wr_q    = 1'b0;
    endtask

    task automatic pulse_wr_rst();
        bus.wr_rst = 1'b1;
        tick();
        bus.wr_rst = 1'b0;
    endtask

    task automatic set_interp(input int v);
        bus.set_interp = 1'b1;
        bus.interp_val = MD'(v);
        tick();
        bus.set_interp = 1'b0;
    endtask

    task automatic do_start(input logic lp);
        bus.loop  = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus.wr_rst     = 1'b0;
        bus.wr_i       = 1'b0;
        bus.wr_q       = 1'b0;
        bus.wr_data    = '0;
        bus.set_interp = 1'b0;
        bus.interp_val = '0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.loop       = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_strobe", bus.out_strobe, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_done",   bus.done, 0);
        chk("rst_out_i",  bus.out_i, 0);
        chk("rst_out_q",  bus.out_q, 0);
        chk("rst_wrcnt",  bus.wr_count, 0);
        chk("rst_ovf",    bus.overflow, 0);
        rst = 1'b0;
        tick();

        // one-shot, interp 3: strobes at P+1,P+4,P+7,P+10, done at P+13
        for (int n = 0; n < 4; n++) write_pair(10 + n, -(10 + n));
        chk("load4_wrcnt", bus.wr_count, 4);
        set_interp(3);
        do_start(1'b0);
        for (int t = 0; t <= 14; t++) begin
            chk("os_strobe", bus.out_strobe, (t >= 1 && t <= 10 && (t - 1) % 3 == 0));
            chk("os_busy",   bus.busy, (t <= 12));
            chk("os_done",   bus.done, (t == 13));
            chk("os_out_i",  bus.out_i, (t >= 1 && t <= 12) ? 10 + (t - 1) / 3 : 0);
            chk("os_out_q",  bus.out_q, (t >= 1 && t <= 12) ? -(10 + (t - 1) / 3) : 0);
            tick();
        end

        // continuous, interp 1: 0,1,2,3,0,1 back to back, then stop
        set_interp(1);
        do_start(1'b1);
        for (int t = 0; t <= 6; t++) begin
            chk("lp_strobe", bus.out_strobe, (t >= 1));
            chk("lp_out_i",  bus.out_i, (t >= 1) ? 10 + (t - 1) % 4 : 0);
            if (t < 6) tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_busy",   bus.busy, 0);
        chk("stop_strobe", bus.out_strobe, 0);
        chk("stop_done",   bus.done, 0);
        chk("stop_out_i",  bus.out_i, 0);
        tick();
        chk("stop_done2",  bus.done, 0);

        // interp_val 0 behaves as 1
        set_interp(0);
        do_start(1'b0);
        for (int t = 0; t <= 5; t++) begin
            chk("i0_strobe", bus.out_strobe, (t >= 1 && t <= 4));
            chk("i0_out_q",  bus.out_q, (t >= 1 && t <= 4) ? -(10 + t - 1) : 0);
            chk("i0_done",   bus.done, (t == 5));
            tick();
        end

        // empty buffer: start ignored
        pulse_wr_rst();
        chk("wrrst_cnt", bus.wr_count, 0);
        do_start(1'b0);
        chk("empty_busy", bus.busy, 0);
        tick();
        chk("empty_strobe", bus.out_strobe, 0);

        // overflow: DEPTH+2 pairs
        for (int n = 0; n < DEPTH + 2; n++) write_pair(n, n);
        chk("ovf_cnt",  bus.wr_count, DEPTH);
        chk("ovf_flag", bus.overflow, 1);
        pulse_wr_rst();
        chk("ovf_clr_cnt",  bus.wr_count, 0);
        chk("ovf_clr_flag", bus.overflow, 0);

        // start and stop together: stop wins
        for (int n = 0; n < 4; n++) write_pair(10 + n, -(10 + n));
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss_busy", bus.busy, 0);

        // interp 4 -> 2 mid-period: strobes at P+1, P+5, P+7, P+9
        set_interp(4);
        do_start(1'b1);
        chk("mid_prime_busy", bus.busy, 1);
        tick();
        chk("mid_stb1", bus.out_strobe, 1);
        tick();
        for (int t = 2; t <= 9; t++) begin
            chk("mid_strobe", bus.out_strobe, (t == 5 || t == 7 || t == 9));
            chk("mid_out_i",  bus.out_i, (t < 5) ? 10 : (t < 7) ? 11 : (t < 9) ? 12 : 13);
            if (t == 2) begin
                bus.set_interp = 1'b1;
                bus.interp_val = MD'(2);
            end
            if (t < 9) begin
                tick();
                bus.set_interp = 1'b0;
            end
        end

        // asynchronous reset while playing
        rst = 1'b1;
        #1;
        chk("arst_strobe", bus.out_strobe, 0);
        chk("arst_busy",   bus.busy, 0);
        chk("arst_out_i",  bus.out_i, 0);
        chk("arst_out_q",  bus.out_q, 0);
        chk("arst_wrcnt",  bus.wr_count, 0);
        #2;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) write_pair(20 + n, -(20 + n));
        do_start(1'b0);
        chk("rs_prime_busy",   bus.busy, 1);
        chk("rs_prime_strobe", bus.out_strobe, 0);
        tick();
        chk("rs_strobe", bus.out_strobe, 1);
        chk("rs_out_i",  bus.out_i, 20);
        chk("rs_out_q",  bus.out_q, -20);
        tick();
        chk("rs_strobe2", bus.out_strobe, 1);
        chk("rs_out_i2",  bus.out_i, 21);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
